rvc_fetch_align: RTL and testbench
==================================

RVC_FETCH_ALIGN -- requirements
Module: rvc_fetch_align

Interface
REQ-001 SHALL provide clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide proc_reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide fetch_req  input  1  pipeline requests the instruction at fetch_pc; held with stable fetch_pc until fetch_valid.
REQ-004 SHALL provide fetch_pc  input  31  halfword address, byte address bits [31:1].
REQ-005 SHALL provide fetch_flush  input  1  abandons the current request after a redirect.
REQ-006 SHALL provide fetch_inst  output  32  aligned instruction; 16-bit instructions zero-extended in [31:16].
REQ-007 SHALL provide fetch_len  output  1  1 = 32-bit instruction (PC+4), 0 = compressed (PC+2).
REQ-008 SHALL provide fetch_valid  output  1  one-cycle pulse: fetch_inst/fetch_len valid.
REQ-009 SHALL provide fetch_stall  output  1  equals fetch_req & ~fetch_valid.
REQ-010 SHALL provide ICACHE_ren  output  1  I-cache read request.
REQ-011 SHALL provide ICACHE_addr  output  30  word address (byte bits [31:2]).
REQ-012 SHALL provide ICACHE_rdata  input  32  I-cache read data, valid in the cycle ICACHE_stall is low while ICACHE_ren is high.
REQ-013 SHALL provide ICACHE_stall  input  1  I-cache busy; the read completes in the first ren-high cycle with stall low.

Function
REQ-014 SHALL hold a one-word buffer: buf_addr[29:0], buf_data[31:0], buf_valid.
REQ-015 SHALL define W = fetch_pc[30:1], h = fetch_pc[0]; the selected halfword is the low half (h=0) or high half (h=1) of word W.
REQ-016 SHALL classify the selected halfword as 32-bit when its bits [1:0] == 2'b11, else compressed.
REQ-017 SHALL implement states IDLE, FETCH0, FETCH1, RESP, encoded 2 bits, reset to IDLE.
REQ-018 IDLE with fetch_req=1 and fetch_flush=0: buffer miss on W -> FETCH0; hit on W, straddling (h=1 and 32-bit) -> FETCH1; hit, non-straddling -> RESP.
REQ-019 FETCH0 SHALL drive ICACHE_ren=1 and ICACHE_addr=W; on completion load the buffer with W and the data, then -> FETCH1 if straddling, else -> RESP.
REQ-020 FETCH1 SHALL drive ICACHE_ren=1 and ICACHE_addr=W+1 mod 2^30; on completion form fetch_inst={rdata[15:0], buf_data[31:16]}, then load the buffer with W+1 and go to RESP.
REQ-021 RESP SHALL assert fetch_valid for exactly one cycle with registered fetch_inst/fetch_len, then -> IDLE.
REQ-022 ICACHE_ren SHALL be 0 in IDLE and RESP; ICACHE_addr SHALL hold stable while ren=1 and stall=1.
REQ-023 Latency SHALL be: buffer hit non-straddling, fetch_valid 2 cycles after fetch_req rises; each I-cache access adds 1 + (stall cycles).
REQ-024 fetch_flush in FETCH0/FETCH1 SHALL keep ren asserted until completion, still update the buffer, then go to IDLE without asserting fetch_valid.
REQ-025 fetch_flush in IDLE or RESP SHALL suppress fetch_valid and force IDLE; flush has priority over fetch_req.
REQ-026 W = 30'h3FFFFFFF straddling SHALL fetch word 0 (wrap-around).
REQ-027 SHALL never invalidate the buffer except on reset.

Reset
REQ-028 proc_reset SHALL asynchronously set state=IDLE, buf_valid=0, buf_addr=0, buf_data=0, fetch_inst=0, fetch_len=0, fetch_valid=0, ICACHE_ren=0, ICACHE_addr=0.
REQ-029 Reset asserted mid-FETCH SHALL drop ICACHE_ren in the same cycle; after release, the first request SHALL miss.

Verification
REQ-030 After reset, pc=0, word0=32'h00A00093, stall 3 cycles -> one read addr 0, fetch_inst=32'h00A00093, len=1.
REQ-031 Buffer word0=32'h4501_4581, pc=0 then pc=1 -> two hits, no ren, inst 32'h00004581 then 32'h00004501, len=0.
REQ-032 Straddle: word4=32'h0093_4505 (upper 16'h0093), word5=32'h????_00A0, pc byte 0x12 -> reads addr 4, 5, inst=32'h00A00093, len=1, buf_addr=5.
REQ-033 Wrap: straddling pc byte 0xFFFFFFFE -> second read ICACHE_addr=30'h0.
REQ-034 fetch_flush during FETCH0 with stall -> ren held to completion, no fetch_valid, state IDLE.
REQ-035 proc_reset pulse during FETCH1 -> ren=0 immediately, buf_valid=0, next request issues FETCH0.

Source files
------------

// File: rtl/rvc_fetch_align_if.sv
// Fetch-side handshake and I-cache read port of the RVC fetch aligner.
// The slave modport is the aligner; the master modport is the pipeline plus I-cache.
interface rvc_fetch_align_if;
   logic        fetch_req;
   logic [30:0] fetch_pc;
   logic        fetch_flush;
   logic [31:0] fetch_inst;
   logic        fetch_len;
   logic        fetch_valid;
   logic        fetch_stall;
   logic        ICACHE_ren;
   logic [29:0] ICACHE_addr;
   logic [31:0] ICACHE_rdata;
   logic        ICACHE_stall;

   modport master (
      output fetch_req, fetch_pc, fetch_flush, ICACHE_rdata, ICACHE_stall,
      input  fetch_inst, fetch_len, fetch_valid, fetch_stall, ICACHE_ren, ICACHE_addr
   );

   modport slave (
      input  fetch_req, fetch_pc, fetch_flush, ICACHE_rdata, ICACHE_stall,
      output fetch_inst, fetch_len, fetch_valid, fetch_stall, ICACHE_ren, ICACHE_addr
   );
endinterface

// File: rtl/rvc_fetch_align.sv
// Aligns 16/32-bit RISC-V instructions from a word-wide I-cache using a one-word buffer;
// instructions straddling a word boundary take a second read of the following word.
module rvc_fetch_align (
   input  logic                 clk,
   input  logic                 proc_reset,
   rvc_fetch_align_if.slave     bus
);

   typedef enum logic [1:0] {StIdle, StFetch0, StFetch1, StResp} state_e;

   state_e      state_q;
   logic        buf_valid_q;
   logic [29:0] buf_addr_q;
   logic [31:0] buf_data_q;
   logic [31:0] inst_q;
   logic        len_q;
   logic        valid_q;
   logic        ren_q;
   logic [29:0] addr_q;
   logic        h_q;
   logic        flush_q;

   logic [29:0] req_w;
   logic        req_h;
   logic        buf_hit;
   logic [15:0] buf_half;
   logic        buf_is32;
   logic        buf_straddle;
   logic [15:0] rd_half;
   logic        rd_is32;
   logic        rd_straddle;
   logic        rd_done;
   logic        abandon;

   assign req_w        = bus.fetch_pc[30:1];
   assign req_h        = bus.fetch_pc[0];
   assign buf_hit      = buf_valid_q && (buf_addr_q == req_w);
   assign buf_half     = req_h ? buf_data_q[31:16] : buf_data_q[15:0];
   assign buf_is32     = (buf_half[1:0] == 2'b11);
   assign buf_straddle = req_h && buf_is32;

   assign rd_half     = h_q ? bus.ICACHE_rdata[31:16] : bus.ICACHE_rdata[15:0];
   assign rd_is32     = (rd_half[1:0] == 2'b11);
   assign rd_straddle = h_q && rd_is32;
   assign rd_done     = ren_q && !bus.ICACHE_stall;
   // A flush seen at any point of an outstanding read abandons it once the read lands.
   assign abandon     = flush_q || bus.fetch_flush;

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state_q     <= StIdle;
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         inst_q      <= '0;
         len_q       <= 1'b0;
         valid_q     <= 1'b0;
         ren_q       <= 1'b0;
         addr_q      <= '0;
         h_q         <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               // While the pulse is out the pipeline still presents the completed request.
               if (bus.fetch_req && !bus.fetch_flush && !valid_q) begin
                  h_q     <= req_h;
                  flush_q <= 1'b0;
                  if (!buf_hit) begin
                     state_q <= StFetch0;
                     ren_q   <= 1'b1;
                     addr_q  <= req_w;
                  end else if (buf_straddle) begin
                     state_q <= StFetch1;
                     ren_q   <= 1'b1;
                     addr_q  <= req_w + 30'd1;
                  end else begin
                     state_q <= StResp;
                     inst_q  <= buf_is32 ? buf_data_q : {16'h0000, buf_half};
                     len_q   <= buf_is32;
                  end
               end
            end
            StFetch0: begin
               if (bus.fetch_flush) flush_q <= 1'b1;
               if (rd_done) begin
                  buf_valid_q <= 1'b1;
                  buf_addr_q  <= addr_q;
                  buf_data_q  <= bus.ICACHE_rdata;
                  if (abandon) begin
                     state_q <= StIdle;
                     ren_q   <= 1'b0;
                  end else if (rd_straddle) begin
                     state_q <= StFetch1;
                     addr_q  <= addr_q + 30'd1;
                  end else begin
                     state_q <= StResp;
                     ren_q   <= 1'b0;
                     inst_q  <= rd_is32 ? bus.ICACHE_rdata : {16'h0000, rd_half};
                     len_q   <= rd_is32;
                  end
               end
            end
            StFetch1: begin
               if (bus.fetch_flush) flush_q <= 1'b1;
               if (rd_done) begin
                  buf_valid_q <= 1'b1;
                  buf_addr_q  <= addr_q;
                  buf_data_q  <= bus.ICACHE_rdata;
                  ren_q       <= 1'b0;
                  if (abandon) begin
                     state_q <= StIdle;
                  end else begin
                     state_q <= StResp;
                     inst_q  <= {bus.ICACHE_rdata[15:0], buf_data_q[31:16]};
                     len_q   <= 1'b1;
                  end
               end
            end
            StResp: begin
               state_q <= StIdle;
               valid_q <= !bus.fetch_flush;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.fetch_inst  = inst_q;
   assign bus.fetch_len   = len_q;
   assign bus.fetch_valid = valid_q;
   assign bus.fetch_stall = bus.fetch_req & ~valid_q;
   assign bus.ICACHE_ren  = ren_q;
   assign bus.ICACHE_addr = addr_q;

endmodule

// File: tb/tb_rvc_fetch_align.sv
// Bench for rvc_fetch_align: directed vector table, flush/reset sequences and
// randomized fetches checked against a word-level memory/buffer model.
module tb_rvc_fetch_align;

   logic clk = 1'b0;
   logic proc_reset;

   rvc_fetch_align_if bus ();

   rvc_fetch_align dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_ovr [logic [29:0]];
   logic [29:0] rd_q [$];
   int          stall_cycles = 0;
   int          run_cnt      = 0;
   int          stall_fixed  = 0;
   bit          stall_rand   = 1'b0;

   bit          m_valid;
   logic [29:0] m_addr;
   logic [31:0] m_data;

   typedef struct {
      bit          rst;
      bit          wr;
      logic [29:0] wa;
      logic [31:0] wd;
      logic [30:0] pc;
      int          stall;
      logic [31:0] inst;
      logic        len;
      int          nrd;
      logic [29:0] last;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [31:0] mem_rd(input logic [29:0] a);
      logic [31:0] x;
      if (mem_ovr.exists(a)) return mem_ovr[a];
      x = {a, 2'b01} * 32'h9E3779B1;
      return x ^ (x >> 13);
   endfunction

   // I-cache model: data for the presented address, stall chosen per cycle, reads logged.
   always @(negedge clk) begin
      bus.ICACHE_rdata = mem_rd(bus.ICACHE_addr);
      if (bus.ICACHE_ren) begin
         if (stall_rand) bus.ICACHE_stall = ($urandom_range(0, 2) == 0);
         else            bus.ICACHE_stall = (run_cnt < stall_fixed);
         if (bus.ICACHE_stall) begin
            stall_cycles++;
            run_cnt++;
         end else begin
            rd_q.push_back(bus.ICACHE_addr);
            run_cnt = 0;
         end
      end else begin
         bus.ICACHE_stall = 1'b0;
         run_cnt = 0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.fetch_req   = 1'b0;
      bus.fetch_flush = 1'b0;
      bus.fetch_pc    = '0;
      proc_reset      = 1'b1;
      tick();
      tick();
      check("rst.ren",   bus.ICACHE_ren,  1'b0);
      check("rst.addr",  bus.ICACHE_addr, 30'h0);
      check("rst.valid", bus.fetch_valid, 1'b0);
      check("rst.inst",  bus.fetch_inst,  32'h0);
      check("rst.len",   bus.fetch_len,   1'b0);
      proc_reset = 1'b0;
      tick();
      m_valid = 1'b0;
      rd_q.delete();
      stall_cycles = 0;
   endtask

   task automatic do_fetch(input logic [30:0] pc, input string tag,
                           output logic [31:0] inst, output logic len, output int lat);
      int n;
      rd_q.delete();
      stall_cycles = 0;
      bus.fetch_pc  = pc;
      bus.fetch_req = 1'b1;
      tick();
      n = 1;
      check({tag, ".stall_hi"}, bus.fetch_stall, 1'b1);
      while (!bus.fetch_valid && n < 200) begin
         tick();
         n++;
      end
      check({tag, ".valid"},    bus.fetch_valid, 1'b1);
      check({tag, ".stall_lo"}, bus.fetch_stall, 1'b0);
      inst = bus.fetch_inst;
      len  = bus.fetch_len;
      lat  = n;
      bus.fetch_req = 1'b0;
      tick();
      check({tag, ".pulse"}, bus.fetch_valid, 1'b0);
   endtask

   // Reference: instruction and word reads implied by the PC, memory and one-word buffer.
   task automatic model_fetch(input logic [30:0] pc, input string tag);
      logic [29:0] w;
      logic [31:0] first;
      logic [31:0] second;
      logic [31:0] e_inst;
      logic        e_len;
      logic [15:0] half;
      logic [29:0] e_rd [$];
      logic [31:0] a_inst;
      logic        a_len;
      int          lat;
      w = pc[30:1];
      if (m_valid && m_addr == w) begin
         first = m_data;
      end else begin
         first = mem_rd(w);
         e_rd.push_back(w);
      end
      half    = pc[0] ? first[31:16] : first[15:0];
      m_valid = 1'b1;
      m_addr  = w;
      m_data  = first;
      if (pc[0] && half[1:0] == 2'b11) begin
         second = mem_rd(w + 30'd1);
         e_rd.push_back(w + 30'd1);
         e_inst = {second[15:0], half};
         e_len  = 1'b1;
         m_addr = w + 30'd1;
         m_data = second;
      end else if (half[1:0] == 2'b11) begin
         e_inst = first;
         e_len  = 1'b1;
      end else begin
         e_inst = {16'h0000, half};
         e_len  = 1'b0;
      end
      do_fetch(pc, tag, a_inst, a_len, lat);
      check({tag, ".inst"}, a_inst, e_inst);
      check({tag, ".len"},  a_len,  e_len);
      check({tag, ".nrd"},  rd_q.size(), e_rd.size());
      for (int i = 0; i < e_rd.size() && i < rd_q.size(); i++)
         check($sformatf("%s.rd%0d", tag, i), rd_q[i], e_rd[i]);
      check({tag, ".lat"}, lat, 2 + e_rd.size() + stall_cycles);
   endtask

   initial begin
      logic [31:0] a_inst;
      logic        a_len;
      int          lat;
      int          n;
      int          nv;
      int          nr;

      vecs[0] = '{1'b1, 1'b1, 30'h0, 32'h00A00093, 31'h0, 3, 32'h00A00093, 1'b1, 1, 30'h0};
      vecs[1] = '{1'b1, 1'b1, 30'h0, 32'h45014581, 31'h0, 0, 32'h00004581, 1'b0, 1, 30'h0};
      vecs[2] = '{1'b0, 1'b0, 30'h0, 32'h0, 31'h1, 0, 32'h00004501, 1'b0, 0, 30'h0};
      vecs[3] = '{1'b0, 1'b0, 30'h0, 32'h0, 31'h0, 0, 32'h00004581, 1'b0, 0, 30'h0};
      vecs[4] = '{1'b0, 1'b0, 30'h0, 32'h0, 31'h9, 1, 32'h00A00093, 1'b1, 2, 30'h5};
      vecs[5] = '{1'b0, 1'b0, 30'h0, 32'h0, 31'hA, 0, 32'h000000A0, 1'b0, 0, 30'h0};
      vecs[6] = '{1'b0, 1'b1, 30'h3FFFFFFF, 32'hABCF1234, 31'h7FFFFFFF, 2,
                  32'h4581ABCF, 1'b1, 2, 30'h0};
      vecs[7] = '{1'b0, 1'b0, 30'h0, 32'h0, 31'h0, 0, 32'h00004581, 1'b0, 0, 30'h0};
      vecs[8] = '{1'b0, 1'b1, 30'h3, 32'h00410113, 31'h6, 0, 32'h00410113, 1'b1, 1, 30'h3};
      vecs[9] = '{1'b0, 1'b0, 30'h0, 32'h0, 31'h7, 0, 32'h00000041, 1'b0, 0, 30'h0};

      mem_ovr[30'h4] = 32'h00934505;
      mem_ovr[30'h5] = 32'h123400A0;

      do_reset();
      stall_rand = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].rst) do_reset();
         if (vecs[i].wr) mem_ovr[vecs[i].wa] = vecs[i].wd;
         stall_fixed = vecs[i].stall;
         do_fetch(vecs[i].pc, $sformatf("v%0d", i), a_inst, a_len, lat);
         check($sformatf("v%0d.inst", i), a_inst, vecs[i].inst);
         check($sformatf("v%0d.len", i), a_len, vecs[i].len);
         check($sformatf("v%0d.nrd", i), rd_q.size(), vecs[i].nrd);
         check($sformatf("v%0d.lat", i), lat, 2 + vecs[i].nrd * (1 + vecs[i].stall));
         if (vecs[i].nrd > 0 && rd_q.size() > 0)
            check($sformatf("v%0d.last", i), rd_q[rd_q.size() - 1], vecs[i].last);
      end

      // Flush while the first read is stalled: read completes, buffer fills, no response.
      do_reset();
      mem_ovr[30'h10] = 32'h12345679;
      stall_fixed = 4;
      bus.fetch_pc  = 31'h20;
      bus.fetch_req = 1'b1;
      n = 0;
      while (!bus.ICACHE_ren && n < 10) begin
         tick();
         n++;
      end
      check("fl.ren_up", bus.ICACHE_ren,  1'b1);
      check("fl.addr",   bus.ICACHE_addr, 30'h10);
      bus.fetch_flush = 1'b1;
      bus.fetch_req   = 1'b0;
      tick();
      bus.fetch_flush = 1'b0;
      check("fl.ren_hold", bus.ICACHE_ren, 1'b1);
      nv = 0;
      n  = 0;
      while (bus.ICACHE_ren && n < 20) begin
         tick();
         n++;
         if (bus.fetch_valid) nv++;
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bus.fetch_valid) nv++;
      end
      check("fl.no_valid", nv, 0);
      check("fl.ren_down", bus.ICACHE_ren, 1'b0);
      check("fl.nrd", rd_q.size(), 1);
      m_valid = 1'b1;
      m_addr  = 30'h10;
      m_data  = 32'h12345679;
      stall_fixed = 0;
      model_fetch(31'h20, "fl.hit");

      // Flush together with a request in IDLE: nothing starts.
      bus.fetch_pc    = 31'h40;
      bus.fetch_req   = 1'b1;
      bus.fetch_flush = 1'b1;
      nv = 0;
      nr = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.fetch_valid) nv++;
         if (bus.ICACHE_ren) nr++;
      end
      check("fi.valid", nv, 0);
      check("fi.ren",   nr, 0);
      bus.fetch_flush = 1'b0;
      bus.fetch_req   = 1'b0;
      tick();

      // Flush in the response cycle of a buffer hit suppresses the pulse.
      bus.fetch_pc  = 31'h20;
      bus.fetch_req = 1'b1;
      tick();
      bus.fetch_flush = 1'b1;
      bus.fetch_req   = 1'b0;
      tick();
      check("fr.valid0", bus.fetch_valid, 1'b0);
      bus.fetch_flush = 1'b0;
      tick();
      check("fr.valid1", bus.fetch_valid, 1'b0);
      check("fr.ren",    bus.ICACHE_ren,  1'b0);

      // Reset while the second word of a straddle is outstanding.
      do_reset();
      stall_fixed   = 3;
      bus.fetch_pc  = 31'h9;
      bus.fetch_req = 1'b1;
      n = 0;
      while (!(bus.ICACHE_ren && bus.ICACHE_addr == 30'h5) && n < 40) begin
         tick();
         n++;
      end
      check("rs.fetch1", {bus.ICACHE_ren, bus.ICACHE_addr}, {1'b1, 30'h5});
      #2 proc_reset = 1'b1;
      #1;
      check("rs.ren",   bus.ICACHE_ren,  1'b0);
      check("rs.addr",  bus.ICACHE_addr, 30'h0);
      check("rs.valid", bus.fetch_valid, 1'b0);
      bus.fetch_req = 1'b0;
      tick();
      proc_reset = 1'b0;
      tick();
      m_valid     = 1'b0;
      stall_fixed = 1;
      model_fetch(31'h9, "rs.miss");

      // Randomized fetches around low memory and the top-of-memory wrap.
      do_reset();
      stall_rand = 1'b1;
      for (int t = 0; t < 150; t++) begin
         logic [29:0] w;
         logic [30:0] pc;
         case ($urandom_range(0, 9))
            0:       w = 30'h3FFFFFFF;
            1:       w = 30'h3FFFFFFE;
            default: w = 30'($urandom_range(0, 7));
         endcase
         if (m_valid && $urandom_range(0, 2) == 0) w = m_addr;
         if ($urandom_range(0, 7) == 0) mem_ovr[w] = $urandom();
         pc = {w, ($urandom_range(0, 1) == 1)};
         model_fetch(pc, $sformatf("r%0d", t));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
